bram_sp_fifo_ctrl: RTL and testbench

BRAM_SP_FIFO_CTRL -- requirements
Module: bram_sp_fifo_ctrl

---
 rtl/bram_sp_fifo_ctrl.sv | 74 +++++++
 tb/tb_bram_sp_fifo_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bram_sp_fifo_ctrl.sv
// rtl/bram_sp_fifo_ctrl.sv - FIFO controller over a single-port sync-write/async-read RAM
// One RAM access per cycle; a toggling priority bit arbitrates read/write conflicts.
module bram_sp_fifo_ctrl #(
   parameter int DW = 4,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [AW:0]   count,
   output logic          ram_we,
   output logic [AW-1:0] ram_a,
   output logic [DW-1:0] ram_di,
   input  logic [DW-1:0] ram_do
);

   localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          prio;
   logic          full;
   logic          wr_req;
   logic          rd_req;
   logic          wr_grant;
   logic          rd_grant;

   // Requests are masked during reset so the RAM is never written while state is cleared.
   assign full     = (count == FULL_CNT);
   assign wr_req   = in_valid & ~full & ~rst;
   assign rd_req   = (count != '0) & (~out_valid | out_ready) & ~rst;
   assign rd_grant = rd_req & (~wr_req | prio);
   assign wr_grant = wr_req & (~rd_req | ~prio);

   assign in_ready = ~full & ~(rd_req & prio) & ~rst;
   assign ram_we   = wr_grant;
   assign ram_di   = in_data;
   assign ram_a    = wr_grant ? wptr : rptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         prio      <= 1'b0;
      end else begin
         if (wr_req & rd_req)
            prio <= ~prio;
         if (wr_grant)
            wptr <= wptr + PTR_ONE;
         if (rd_grant) begin
            out_data  <= ram_do;
            out_valid <= 1'b1;
            rptr      <= rptr + PTR_ONE;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (wr_grant & ~rd_grant)
            count <= count + CNT_ONE;
         else if (rd_grant & ~wr_grant)
            count <= count - CNT_ONE;
      end
   end

endmodule

// File: tb/tb_bram_sp_fifo_ctrl.sv
// tb/tb_bram_sp_fifo_ctrl.sv - self-checking bench for bram_sp_fifo_ctrl
// Queue-based occupancy model plus directed literal expectations.
module tb_bram_sp_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_data = 4'h0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_data;
   logic [5:0] count;
   logic       ram_we;
   logic [4:0] ram_a;
   logic [3:0] ram_di;
   logic [3:0] ram_do;

   logic [3:0] mem [32];

   int total = 0;
   int bad   = 0;

   logic [3:0] q[$];
   logic [3:0] sb[$];
   bit         mv;
   logic [3:0] md;
   bit         mprio;
   int         wp;
   int         rp;
   bit         last_wr;

   bram_sp_fifo_ctrl #(.DW(4), .AW(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do)
   );

   always #5 clk = ~clk;

   assign ram_do = mem[ram_a];
   always @(posedge clk) if (ram_we) mem[ram_a] <= ram_di;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, compare all outputs to the model, advance model past the edge.
   task automatic step(input bit r, input bit iv, input logic [3:0] id, input bit ordy);
      bit full, rdreq, wrreq, wr, rd, exp_ir;
      logic [3:0] exp_w;
      rst = r; in_valid = iv; in_data = id; out_ready = ordy;
      #2;
      full   = (q.size() == 32);
      rdreq  = !r && q.size() != 0 && (!mv || ordy);
      wrreq  = !r && iv && !full;
      exp_ir = !r && !full && !(rdreq && mprio);
      wr     = wrreq && (!rdreq || !mprio);
      rd     = rdreq && (!wrreq || mprio);
      chk("in_ready", int'(in_ready), int'(exp_ir));
      chk("ram_we", int'(ram_we), int'(wr));
      chk("ram_a", int'(ram_a), wr ? wp : rp);
      chk("count", int'(count), q.size());
      chk("out_valid", int'(out_valid), int'(mv));
      if (mv) chk("out_data", int'(out_data), int'(md));
      if (wr) chk("ram_di", int'(ram_di), int'(id));
      if (!r && mv && ordy) begin
         if (sb.size() == 0) chk("order_underflow", 1, 0);
         else begin
            exp_w = sb.pop_front();
            chk("order", int'(out_data), int'(exp_w));
         end
      end
      last_wr = wr;
      if (r) begin
         q.delete(); sb.delete();
         mv = 0; md = 4'h0; mprio = 0; wp = 0; rp = 0;
      end else begin
         if (wrreq && rdreq) mprio = !mprio;
         if (wr) begin
            q.push_back(id); sb.push_back(id); wp = (wp + 1) % 32;
         end
         if (rd) begin
            md = q.pop_front(); mv = 1; rp = (rp + 1) % 32;
         end else if (ordy) mv = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] id, input bit ordy);
      int n = 0;
      do begin
         step(0, 1, id, ordy);
         n++;
      end while (!last_wr && n < 100);
      if (!last_wr) chk("push_timeout", 0, 1);
   endtask

   task automatic do_reset();
      step(1, 0, 4'h0, 0);
      step(1, 0, 4'h0, 0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 4'h0;
      mv = 0; md = 0; mprio = 0; wp = 0; rp = 0; last_wr = 0;

      // Reset state
      do_reset();
      chk("rst_count", int'(count), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);

      // Three pushes, no drain: one word moves to the output register
      push(4'h1, 0);
      push(4'h2, 0);
      push(4'h3, 0);
      chk("p3_count", int'(count), 2);
      chk("p3_out_valid", int'(out_valid), 1);
      chk("p3_out_data", int'(out_data), 1);
      step(0, 0, 4'h0, 0);
      step(0, 0, 4'h0, 0);
      chk("p3_hold_data", int'(out_data), 1);
      chk("p3_hold_count", int'(count), 2);

      // Fill: 33 words accepted, 34th refused
      do_reset();
      for (int i = 0; i < 33; i++) push(4'(i), 0);
      chk("full_count", int'(count), 32);
      chk("full_out_valid", int'(out_valid), 1);
      chk("full_out_data", int'(out_data), 0);
      step(0, 1, 4'hF, 0);
      chk("full_in_ready", int'(in_ready), 0);
      chk("full_ram_we", int'(ram_we), 0);
      chk("full_count2", int'(count), 32);

      // From full, stream both sides continuously
      for (int i = 0; i < 60; i++) step(0, 1, 4'($urandom_range(0, 15)), 1);
      for (int i = 0; i < 40; i++) step(0, 0, 4'h0, 1);
      chk("stream_drained", sb.size(), 0);
      chk("stream_count", int'(count), 0);

      // 40 words with concurrent drain: pointers wrap 31 -> 0
      do_reset();
      for (int i = 0; i < 40; i++) push(4'(i * 7 + 3), 1);
      for (int i = 0; i < 40; i++) step(0, 0, 4'h0, 1);
      chk("wrap_drained", sb.size(), 0);
      chk("wrap_rptr", int'(ram_a), 8);
      chk("wrap_out_valid", int'(out_valid), 0);

      // Mid-stream reset with count=10, out_valid=1
      do_reset();
      for (int i = 0; i < 11; i++) push(4'(i + 2), 0);
      chk("pre_rst_count", int'(count), 10);
      chk("pre_rst_out_valid", int'(out_valid), 1);
      step(1, 0, 4'h0, 0);
      chk("post_rst_count", int'(count), 0);
      chk("post_rst_out_valid", int'(out_valid), 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", int'(in_ready), 1);
      push(4'hA, 0);
      step(0, 0, 4'h0, 0);
      chk("post_rst_first_valid", int'(out_valid), 1);
      chk("post_rst_first_data", int'(out_data), 10);
      step(0, 0, 4'h0, 1);

      // Random traffic against the model
      for (int i = 0; i < 10000; i++)
         step(($urandom_range(0, 999) == 0), $urandom_range(0, 1) == 1,
              4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
